// File: rtl/mem_arbiter.sv
// Two-port block-memory arbiter between the I-cache (port 0) and D-cache (port 1).
// One owner at a time; a completed writeback locks the next grant to the same port.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_read0,
  input  logic               req_write0,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [BLOCK_W-1:0] wdata0,
  input  logic               req_read1,
  input  logic               req_write1,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [BLOCK_W-1:0] wdata1,
  output logic               ready0,
  output logic               ready1,
  output logic [BLOCK_W-1:0] rdata0,
  output logic [BLOCK_W-1:0] rdata1,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam int unsigned OFF_W = $clog2(BLOCK_W / 8);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;  // 1 = write
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic                 rr_last_q, rr_last_d;
  logic                 lock_valid_q, lock_valid_d;
  logic                 lock_id_q, lock_id_d;

  logic                 req0, req1, sel;
  logic [ADDR_W-1:0]    sel_addr;

  // Arbitration: lock first, then lone requester, then tie-break.
  always_comb begin
    req0 = req_read0 | req_write0;
    req1 = req_read1 | req_write1;
    if (lock_valid_q && (lock_id_q ? req1 : req0)) begin
      sel = lock_id_q;
    end else if (req0 && !req1) begin
      sel = 1'b0;
    end else if (req1 && !req0) begin
      sel = 1'b1;
    end else if (FIXED_PRIO != 0) begin
      sel = 1'b1;
    end else begin
      sel = ~rr_last_q;
    end
    sel_addr = sel ? addr1 : addr0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rr_last_q    <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rr_last_q    <= rr_last_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rr_last_d    = rr_last_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    unique case (state_q)
      StIdle: begin
        lock_valid_d = 1'b0;
        if (req0 || req1) begin
          state_d            = sel ? StBusy1 : StBusy0;
          op_d               = sel ? req_write1 : req_write0;
          addr_d             = sel_addr;
          addr_d[OFF_W-1:0]  = '0;
          wdata_d            = sel ? wdata1 : wdata0;
          rr_last_d          = sel;
        end
      end
      StBusy0, StBusy1: begin
        if (mem_ready) begin
          state_d = StIdle;
          if (op_q) begin
            lock_valid_d = 1'b1;
            lock_id_d    = (state_q == StBusy1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mem_read  = busy & ~op_q;
    mem_write = busy & op_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    grant     = {state_q == StBusy1, state_q == StBusy0};
    ready0    = (state_q == StBusy0) & mem_ready;
    ready1    = (state_q == StBusy1) & mem_ready;
    rdata0    = (state_q == StBusy0) ? mem_rdata : '0;
    rdata1    = (state_q == StBusy1) ? mem_rdata : '0;
  end

endmodule
